regfile_wb_ctrl: RTL



---
 rtl/regfile_wb_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates NREQ writeback sources onto the register-file write
// port and tracks destinations awaiting writeback. Define REGFILE_WB_RR_EN for round-robin.
module regfile_wb_ctrl #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 wr_en,
    output logic [4:0]           wr_rd,
    output logic [XLEN-1:0]      wr_data
);
    // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i];
    // it holds req_valid/req_rd/req_data stable until then. req_ready is one-hot or 0.
    logic [NREQ-1:0] grant;
    logic            hs;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_rd_q, wr_rd_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [31:0]     busy_q, busy_d;

`ifdef REGFILE_WB_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;

    // Search starts at the pointer and wraps around modulo NREQ.
    always_comb begin
        logic [PW:0] idx;
        logic        found;
        idx   = '0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && req_valid[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    // No grant is visible while reset is held, so reset dominates any handshake.
    assign req_ready = reset ? '0 : grant;
    assign hs        = |req_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*5 +: 5];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        wr_en_d   = hs && (sel_rd != 5'd0);
        wr_rd_d   = hs ? sel_rd : wr_rd_q;
        wr_data_d = hs ? sel_data : wr_data_q;
    end

    // A fresh issue to the same register outranks the retiring write: new producer pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_rd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_rd    = wr_rd_q;
    assign wr_data  = wr_data_q;
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];

endmodule
